// File: rtl/sram_axi_bridge.sv
// Bridges the cache sram-like request port onto single-beat AXI read/write transactions.
// Build option: SRAM_AXI_RDATA_REG_EN registers read data and inserts an RDONE state (3-cycle read).
`timescale 1ns/1ps

module sram_axi_bridge #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    // sram-like side
    input  logic                  req,
    input  logic                  wr,
    input  logic [1:0]            size,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  addr_ok,
    output logic                  data_ok,
    // AXI read channels
    output logic [ADDR_WIDTH-1:0] araddr,
    output logic [2:0]            arsize,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [DATA_WIDTH-1:0] axi_rdata,
    input  logic                  rvalid,
    output logic                  rready,
    // AXI write channels
    output logic [ADDR_WIDTH-1:0] awaddr,
    output logic [2:0]            awsize,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [DATA_WIDTH-1:0] axi_wdata,
    output logic [3:0]            wstrb,
    output logic                  wvalid,
    input  logic                  wready,
    input  logic                  bvalid,
    output logic                  bready
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR,
        WB
`ifdef SRAM_AXI_RDATA_REG_EN
        , RDONE
`endif
    } state_t;

    state_t                  state_reg;
    logic [1:0]              size_reg;
    logic [ADDR_WIDTH-1:0]   addr_reg;
    logic [DATA_WIDTH-1:0]   wdata_reg;
    logic [3:0]              wstrb_reg;
    logic                    arvalid_reg;
    logic                    rready_reg;
    logic                    awvalid_reg;
    logic                    wvalid_reg;
    logic                    bready_reg;
    logic [3:0]              strb_next;
    logic                    r_fire;
    logic                    aw_done_next;
    logic                    w_done_next;

    // Byte lane enables: word/triple sizes use all lanes, byte and half pick by low address bits.
    for (genvar gi = 0; gi < 4; gi++) begin : g_strb
        localparam logic [1:0] LANE = 2'(gi);
        assign strb_next[gi] = size[1]
                             | ((size == 2'd0) && (addr[1:0] == LANE))
                             | ((size == 2'd1) && (addr[1] == LANE[1]));
    end

    assign r_fire       = (state_reg == RD) && rready_reg && rvalid;
    assign aw_done_next = !awvalid_reg || awready;
    assign w_done_next  = !wvalid_reg || wready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            size_reg    <= '0;
            addr_reg    <= '0;
            wdata_reg   <= '0;
            wstrb_reg   <= '0;
            arvalid_reg <= 1'b0;
            rready_reg  <= 1'b0;
            awvalid_reg <= 1'b0;
            wvalid_reg  <= 1'b0;
            bready_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req) begin
                        size_reg  <= size;
                        addr_reg  <= addr;
                        wdata_reg <= wdata;
                        wstrb_reg <= strb_next;
                        if (wr) begin
                            state_reg   <= WR;
                            awvalid_reg <= 1'b1;
                            wvalid_reg  <= 1'b1;
                        end else begin
                            state_reg   <= RD;
                            arvalid_reg <= 1'b1;
                        end
                    end
                end
                RD: begin
                    if (arvalid_reg && arready) begin
                        arvalid_reg <= 1'b0;
                        rready_reg  <= 1'b1;
                    end
                    if (r_fire) begin
                        rready_reg <= 1'b0;
`ifdef SRAM_AXI_RDATA_REG_EN
                        state_reg  <= RDONE;
`else
                        state_reg  <= IDLE;
`endif
                    end
                end
`ifdef SRAM_AXI_RDATA_REG_EN
                RDONE: state_reg <= IDLE;
`endif
                WR: begin
                    // AW and W retire independently; leave only once both have handshaken.
                    if (awvalid_reg && awready) awvalid_reg <= 1'b0;
                    if (wvalid_reg && wready)   wvalid_reg  <= 1'b0;
                    if (aw_done_next && w_done_next) begin
                        state_reg  <= WB;
                        bready_reg <= 1'b1;
                    end
                end
                WB: begin
                    if (bvalid) begin
                        bready_reg <= 1'b0;
                        state_reg  <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

`ifdef SRAM_AXI_RDATA_REG_EN
    logic [DATA_WIDTH-1:0] rdata_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_reg <= '0;
        end else if (r_fire) begin
            rdata_reg <= axi_rdata;
        end
    end

    assign rdata   = rdata_reg;
    assign data_ok = !rst && ((state_reg == RDONE) || ((state_reg == WB) && bvalid));
`else
    assign rdata   = (!rst && r_fire) ? axi_rdata : '0;
    assign data_ok = !rst && (r_fire || ((state_reg == WB) && bvalid));
`endif

    assign addr_ok   = !rst && (state_reg == IDLE) && req;
    assign araddr    = addr_reg;
    assign awaddr    = addr_reg;
    assign arsize    = {1'b0, size_reg};
    assign awsize    = {1'b0, size_reg};
    assign axi_wdata = wdata_reg;
    assign wstrb     = wstrb_reg;
    assign arvalid   = arvalid_reg;
    assign rready    = rready_reg;
    assign awvalid   = awvalid_reg;
    assign wvalid    = wvalid_reg;
    assign bready    = bready_reg;

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Scoreboard bench for sram_axi_bridge: directed requests against an AXI slave with programmable delays.
`timescale 1ns/1ps

module tb_sram_axi_bridge;

`ifdef SRAM_AXI_RDATA_REG_EN
    localparam int RD_EXTRA = 1;
`else
    localparam int RD_EXTRA = 0;
`endif

    logic        clk = 1'b0;
    logic        rst, req, wr;
    logic [1:0]  size;
    logic [31:0] addr, wdata, rdata;
    logic        addr_ok, data_ok;
    logic [31:0] araddr, awaddr, axi_rdata, axi_wdata;
    logic [2:0]  arsize, awsize;
    logic        arvalid, arready, rvalid, rready;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [3:0]  wstrb;

    sram_axi_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .req(req), .wr(wr), .size(size), .addr(addr),
        .wdata(wdata), .rdata(rdata), .addr_ok(addr_ok), .data_ok(data_ok),
        .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
        .axi_rdata(axi_rdata), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
        .axi_wdata(axi_wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { bit is_read; logic [31:0] rdata; int lat; } sb_t;
    typedef struct { logic [31:0] a; logic [2:0] s; } ax_t;
    typedef struct { logic [31:0] d; logic [3:0] strb; } w_t;

    sb_t         sb_q[$];
    int          acc_q[$];
    ax_t         ar_q[$];
    ax_t         aw_q[$];
    w_t          w_q[$];
    logic [31:0] rval_q[$];

    // Slave delays: cycles of ready/valid held low once the channel becomes active
    int ar_delay = 0, r_delay = 0, aw_delay = 0, w_delay = 0, b_delay = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // AXI slave model, updated on the falling edge from last cycle's handshakes
    int          s_ar_cnt, s_r_cnt, s_aw_cnt, s_w_cnt, s_b_cnt;
    bit          s_r_pend, s_aw_done, s_w_done, s_b_pend;
    bit          s_ar_hs, s_r_hs, s_aw_hs, s_w_hs, s_b_hs;
    logic [31:0] s_r_cur;

    initial begin
        arready = 0; rvalid = 0; axi_rdata = 0; awready = 0; wready = 0; bvalid = 0;
        s_ar_cnt = 0; s_r_cnt = 0; s_aw_cnt = 0; s_w_cnt = 0; s_b_cnt = 0;
        s_r_pend = 0; s_aw_done = 0; s_w_done = 0; s_b_pend = 0;
        s_ar_hs = 0; s_r_hs = 0; s_aw_hs = 0; s_w_hs = 0; s_b_hs = 0; s_r_cur = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                arready = 0; rvalid = 0; axi_rdata = 0; awready = 0; wready = 0; bvalid = 0;
                s_ar_cnt = 0; s_r_cnt = 0; s_aw_cnt = 0; s_w_cnt = 0; s_b_cnt = 0;
                s_r_pend = 0; s_aw_done = 0; s_w_done = 0; s_b_pend = 0;
                s_ar_hs = 0; s_r_hs = 0; s_aw_hs = 0; s_w_hs = 0; s_b_hs = 0;
            end else begin
                if (s_r_hs) s_r_pend = 0;
                if (s_ar_hs) begin
                    s_r_pend = 1; s_r_cnt = 0;
                    s_r_cur = (rval_q.size() != 0) ? rval_q.pop_front() : 32'hBAD0BAD0;
                end
                if (s_aw_hs) s_aw_done = 1;
                if (s_w_hs)  s_w_done = 1;
                if (s_b_hs)  s_b_pend = 0;
                if (s_aw_done && s_w_done) begin
                    s_b_pend = 1; s_b_cnt = 0; s_aw_done = 0; s_w_done = 0;
                end
                arready = arvalid && (s_ar_cnt >= ar_delay);
                if (arvalid && !arready) s_ar_cnt++;
                if (arready) s_ar_cnt = 0;
                rvalid = s_r_pend && (s_r_cnt >= r_delay);
                axi_rdata = rvalid ? s_r_cur : 32'h0;
                if (s_r_pend && !rvalid) s_r_cnt++;
                awready = awvalid && !s_aw_done && (s_aw_cnt >= aw_delay);
                if (awvalid && !awready) s_aw_cnt++;
                if (awready) s_aw_cnt = 0;
                wready = wvalid && !s_w_done && (s_w_cnt >= w_delay);
                if (wvalid && !wready) s_w_cnt++;
                if (wready) s_w_cnt = 0;
                bvalid = s_b_pend && (s_b_cnt >= b_delay);
                if (s_b_pend && !bvalid) s_b_cnt++;
                s_ar_hs = arvalid && arready;
                s_r_hs  = rvalid && rready;
                s_aw_hs = awvalid && awready;
                s_w_hs  = wvalid && wready;
                s_b_hs  = bvalid && bready;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT shows a response or handshake
    bit mon_prev_aok = 0;
    initial begin
        sb_t e;
        ax_t x;
        w_t  wd;
        int  a;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                mon_prev_aok = 0;
            end else begin
                if (addr_ok) begin
                    chk("addr_ok_gap", 128'(mon_prev_aok), 128'(0));
                    acc_q.push_back(cyc);
                end
                if (data_ok) begin
                    if (sb_q.size() == 0 || acc_q.size() == 0) begin
                        chk("unexpected_data_ok", 128'(data_ok), 128'(0));
                    end else begin
                        e = sb_q.pop_front();
                        a = acc_q.pop_front();
                        chk("latency", 128'(cyc - a), 128'(e.lat));
                        if (e.is_read) chk("rdata", 128'(rdata), 128'(e.rdata));
                    end
                end
`ifndef SRAM_AXI_RDATA_REG_EN
                if (!data_ok) chk("rdata_idle_zero", 128'(rdata), 128'(0));
`endif
                if (arvalid && arready) begin
                    if (ar_q.size() == 0) chk("unexpected_ar", 128'(arvalid), 128'(0));
                    else begin
                        x = ar_q.pop_front();
                        chk("araddr", 128'(araddr), 128'(x.a));
                        chk("arsize", 128'(arsize), 128'(x.s));
                    end
                end
                if (awvalid && awready) begin
                    if (aw_q.size() == 0) chk("unexpected_aw", 128'(awvalid), 128'(0));
                    else begin
                        x = aw_q.pop_front();
                        chk("awaddr", 128'(awaddr), 128'(x.a));
                        chk("awsize", 128'(awsize), 128'(x.s));
                    end
                end
                if (wvalid && wready) begin
                    if (w_q.size() == 0) chk("unexpected_w", 128'(wvalid), 128'(0));
                    else begin
                        wd = w_q.pop_front();
                        chk("axi_wdata", 128'(axi_wdata), 128'(wd.d));
                        chk("wstrb", 128'(wstrb), 128'(wd.strb));
                    end
                end
                mon_prev_aok = addr_ok;
            end
        end
    end

    // Drive one request and push its expectations; returns on the falling edge after acceptance
    task automatic issue(input bit w, input logic [1:0] sz, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] rv, input logic [3:0] strb,
                         input int lat, input bit hold);
        sb_t e;
        ax_t x;
        w_t  wd;
        int  n;
        @(negedge clk);
        req = 1; wr = w; size = sz; addr = a; wdata = d;
        e.is_read = !w; e.rdata = rv; e.lat = w ? lat : lat + RD_EXTRA;
        sb_q.push_back(e);
        x.a = a; x.s = {1'b0, sz};
        if (w) begin
            aw_q.push_back(x);
            wd.d = d; wd.strb = strb;
            w_q.push_back(wd);
        end else begin
            ar_q.push_back(x);
            rval_q.push_back(rv);
        end
        $display("issue %s addr=%h size=%0d wdata=%h cycle=%0d", w ? "WR" : "RD", a, sz, d, cyc);
        n = 0;
        #1;
        while (!addr_ok && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("accept_timeout", 128'(addr_ok), 128'(1));
        @(negedge clk);
        if (!hold) req = 0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("completion_timeout", 128'(sb_q.size()), 128'(0));
        sb_q.delete();
        @(negedge clk);
    endtask

    localparam logic [31:0] T_ADDR [6] = '{32'h0000_0001, 32'h0000_0202, 32'h0000_0200,
                                           32'h0000_0010, 32'h0000_00FE, 32'h0000_0002};
    localparam logic [1:0]  T_SIZE [6] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd3, 2'd0};
    localparam logic [3:0]  T_STRB [6] = '{4'b0010, 4'b1100, 4'b0011, 4'b1111, 4'b1111, 4'b0100};

    initial begin
        rst = 1; req = 0; wr = 0; size = 0; addr = 0; wdata = 0;
        repeat (3) @(negedge clk);
        #3;
        chk("reset_ctrl", 128'({addr_ok, data_ok, arvalid, rready, awvalid, wvalid, bready,
                                wstrb, arsize, awsize}), 128'(0));
        chk("reset_data", {rdata, araddr, awaddr, axi_wdata}, 128'(0));
        @(negedge clk);
        rst = 0;

        // Word read, zero-wait slave
        issue(0, 2'd2, 32'h1FC0_0004, 32'h0, 32'hDEAD_BEEF, 4'b0, 2, 0);
        wait_idle();

        // Byte write; response held back two cycles
        b_delay = 2;
        issue(1, 2'd0, 32'h0000_0103, 32'h0000_00AB, 32'h0, 4'b1000, 4, 0);
        wait_idle();
        b_delay = 0;

        // Strobe table
        for (int i = 0; i < 6; i++) begin
            issue(1, T_SIZE[i], T_ADDR[i], 32'h1111_0000 + 32'(i), 32'h0, T_STRB[i], 2, 0);
            wait_idle();
        end

        // Skewed write: W handshakes three cycles before AW
        aw_delay = 3;
        issue(1, 2'd2, 32'h0000_0300, 32'hCAFE_F00D, 32'h0, 4'b1111, 5, 0);
        @(negedge clk);
        #3;
        chk("skew_wvalid_dropped", 128'(wvalid), 128'(0));
        chk("skew_awvalid_held", 128'(awvalid), 128'(1));
        chk("skew_no_bready", 128'(bready), 128'(0));
        wait_idle();
        aw_delay = 0;

        // AR backpressure with a changing input address and a pending request
        ar_delay = 5;
        issue(0, 2'd2, 32'h0000_0400, 32'h0, 32'h1111_2222, 4'b0, 7, 0);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            req = 1;
            addr = $urandom;
            #3;
            chk("stall_araddr", 128'(araddr), 128'(32'h0000_0400));
            chk("stall_addr_ok", 128'(addr_ok), 128'(0));
            chk("stall_arvalid", 128'(arvalid), 128'(1));
        end
        @(negedge clk);
        req = 0;
        wait_idle();
        ar_delay = 0;

        // Byte read with delayed R
        r_delay = 2;
        issue(0, 2'd0, 32'h0000_0602, 32'h0, 32'h0077_0000, 4'b0, 4, 0);
        wait_idle();
        r_delay = 0;

        // Reset while waiting on AR
        ar_delay = 10;
        issue(0, 2'd2, 32'h0000_0700, 32'h0, 32'h1234_5678, 4'b0, 2, 0);
        @(negedge clk);
        #3;
        chk("pre_reset_arvalid", 128'(arvalid), 128'(1));
        rst = 1;
        sb_q.delete(); acc_q.delete(); ar_q.delete(); aw_q.delete(); w_q.delete(); rval_q.delete();
        @(negedge clk);
        #3;
        chk("post_reset_ctrl", 128'({arvalid, rready, data_ok, addr_ok, awvalid, wvalid, bready}), 128'(0));
        rst = 0;
        ar_delay = 0;
        issue(0, 2'd2, 32'h0000_0704, 32'h0, 32'h8765_4321, 4'b0, 2, 0);
        wait_idle();

        // Back-to-back reads with req held high
        issue(0, 2'd2, 32'h0000_0500, 32'h0, 32'hA5A5_A5A5, 4'b0, 2, 1);
        issue(0, 2'd2, 32'h0000_0504, 32'h0, 32'h5A5A_5A5A, 4'b0, 2, 0);
        wait_idle();

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
